// File: rtl/uart_char_pkg.sv
// Shared FSM encodings, character constants and the keyboard character filter
// used by the Apple 1 serial keyboard substitute.
package uart_char_pkg;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] O_IDLE    = 2'd0;
    localparam logic [1:0] O_SETUP   = 2'd1;
    localparam logic [1:0] O_STROBE  = 2'd2;
    localparam logic [1:0] O_RELEASE = 2'd3;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] LOWER_A   = 8'h61;
    localparam logic [7:0] LOWER_Z   = 8'h7A;

    // Strip bit 7 and fold lower case onto the upper-case-only Apple 1 set.
    function automatic logic [6:0] filter_char(input logic [7:0] b);
        logic [6:0] c;
        c = b[6:0];
        if (c >= LOWER_A[6:0] && c <= LOWER_Z[6:0]) begin
            c = c - 7'h20;
        end
        return c;
    endfunction

    function automatic logic keep_char(input logic [6:0] c);
        return (c != ASCII_LF[6:0]) && (c != ASCII_NUL[6:0]);
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Small synchronous character FIFO; a push while full succeeds only when a pop
// frees a slot in the same cycle.
module char_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_char_feeder.sv
// UART-to-Apple-1 keyboard bridge: 8N1 receiver, character filter, FIFO and
// the rd/da strobe handshake paced by the terminal's rda.
module uart_char_feeder
    import uart_char_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 218,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       mr_n,
    input  logic       rx,
    input  logic       rda,
    output logic [6:0] rd,
    output logic       da,
    output logic       overrun,
    output logic       frame_err
);

    localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF      = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic          rx_meta, rx_s, rda_meta, rda_s;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic [6:0]    pdata_q, pdata_d;
    logic          ferr_d;
    logic          ovr_d;
    logic [6:0]    filt;
    logic [1:0]    o_state_q, o_state_d;
    logic [6:0]    rd_d;
    logic          da_d;
    logic          pop;
    logic [6:0]    fifo_dout;
    logic          fifo_full, fifo_empty;

    assign filt  = filter_char(shift_q);
    assign ovr_d = push_q && fifo_full && !pop;

    // Receiver: the detect cycle in RX_IDLE counts toward the half-bit delay.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        pdata_d    = pdata_q;
        ferr_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    cnt_d      = CW'(1);
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                    else               bit_d      = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s) begin
                        push_d  = keep_char(filt);
                        pdata_d = filt;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Output handshake: rd loads only on leaving O_IDLE.
    always_comb begin
        o_state_d = o_state_q;
        rd_d      = rd;
        da_d      = da;
        pop       = 1'b0;
        case (o_state_q)
            O_IDLE: begin
                if (!fifo_empty && rda_s) begin
                    pop       = 1'b1;
                    rd_d      = fifo_dout;
                    o_state_d = O_SETUP;
                end
            end
            O_SETUP: begin
                da_d      = 1'b1;
                o_state_d = O_STROBE;
            end
            O_STROBE: begin
                if (!rda_s) begin
                    da_d      = 1'b0;
                    o_state_d = O_RELEASE;
                end
            end
            default: begin
                da_d = 1'b0;
                if (rda_s) o_state_d = O_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rda_meta   <= 1'b0;
            rda_s      <= 1'b0;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            pdata_q    <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            o_state_q  <= O_IDLE;
            rd         <= '0;
            da         <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            rda_meta   <= rda;
            rda_s      <= rda_meta;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            pdata_q    <= pdata_d;
            frame_err  <= ferr_d;
            overrun    <= ovr_d;
            o_state_q  <= o_state_d;
            rd         <= rd_d;
            da         <= da_d;
        end
    end

    char_fifo #(
        .WIDTH (7),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (mr_n),
        .push  (push_q),
        .pop   (pop),
        .din   (pdata_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: doc/uart_char_feeder.md
# uart_char_feeder

Serial keyboard substitute for the Apple 1 video terminal path. Receives 8N1 UART bytes from a host, normalises them to the Apple 1 character set, buffers them in a small FIFO and presents each one on the 7-bit `rd` bus with a `da` strobe. It sits directly upstream of the PIA register/video terminal pair and obeys the terminal's `rda` ready handshake, so characters are never lost while the terminal is busy scrolling or clearing.

## Interface
- `CLKS_PER_BIT`, 218: clock cycles per UART bit (25.175 MHz / 115200); must be ≥ 8.
- `FIFO_DEPTH`, 16: character buffer depth; power of two, ≥ 2.

- `clk`  in  1  system clock (the locked pixel clock).
- `mr_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input, idle high, asynchronous to `clk`.
- `rda`  in  1  terminal ready-for-data, active high, asynchronous to `clk`.
- `rd`  out  7  character code, bits [7:1] of the Apple 1 bus.
- `da`  out  1  data-available strobe; its rising edge clocks the PIA register.
- `overrun`  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- `frame_err`  out  1  one-cycle pulse when a byte is dropped because its stop bit is 0.

## Operation
- `rx` passes through a 2-flop synchroniser with reset value 1. `rda` passes through a 2-flop synchroniser with reset value 0.
- Receiver FSM:
  - RX_IDLE → RX_START on synced `rx`=0.
  - RX_START waits `CLKS_PER_BIT/2` cycles. If `rx` is still 0, go to RX_DATA; otherwise treat it as a false start and return to RX_IDLE.
  - RX_DATA samples 8 bits LSB-first, one every `CLKS_PER_BIT` cycles.
  - RX_STOP samples one bit. If it is 1, push the filtered byte. If it is 0, pulse `frame_err` and push nothing. Either way, return to RX_IDLE.
- Filter, applied before the push:
  - bit 7 cleared;
  - 0x61–0x7A mapped to 0x41–0x5A;
  - 0x0A (LF) and 0x00 dropped silently;
  - everything else, including 0x0D (CR), passed unchanged.
- FIFO:
  - A push when full drops the byte and pulses `overrun`.
  - A push and a pop in the same cycle while full both succeed, with no overrun.
  - Registered output; a byte written into an empty FIFO is poppable on the next cycle.
- Output FSM:
  - O_IDLE: on FIFO not empty and synced `rda`=1, pop and load `rd` → O_SETUP.
  - O_SETUP: `rd` valid, `da`=0, one cycle → O_STROBE.
  - O_STROBE: `da`=1; hold until synced `rda`=0 → O_RELEASE.
  - O_RELEASE: `da`=0; hold until synced `rda`=1 → O_IDLE.
- `rd` changes only on the O_IDLE→O_SETUP transition. It is stable from one cycle before `da` rises until the next load.
- Reset values: `rd`=0, `da`=0, `overrun`=0, `frame_err`=0, FIFO empty, both FSMs idle.
- Reset mid-byte or mid-strobe aborts immediately. `da` drops asynchronously, and the partial byte and all buffered bytes are discarded.

## Timing
- `rda` sampling: synced `rda` lags the port by 2 cycles. `da` never rises while synced `rda`=0.
- Receive latency: the byte is pushed on the cycle after the stop-bit sample. The stop bit is sampled at 9.5 bit times after the start edge, plus 2 synchroniser cycles.
- Push-to-strobe: with an empty FIFO and `rda` already high, `da` rises 3 cycles after the push cycle: 1 cycle pop-ready, 1 cycle O_IDLE→O_SETUP, 1 cycle O_SETUP→O_STROBE.
- Strobe width: `da` stays high for at least 1 cycle and until the terminal drops `rda`. There is no timeout.
- Throughput: one character per full `rda` high→low→high cycle. The receiver runs concurrently with the output FSM.
- Pulses: `overrun` and `frame_err` are registered, exactly 1 cycle wide.

## Structure
- Package `uart_char_pkg`: receiver and output FSM state enums, plus the constants `ASCII_LF`, `ASCII_CR`, `ASCII_NUL` and `LOWER_A`/`LOWER_Z`.
- Sub-module `char_fifo`: synchronous FIFO with parameters `WIDTH`=7 and `DEPTH`, async active-low reset, and ports `push`/`pop`/`full`/`empty`.
- Top level: UART receiver, filter and output FSM.

## Test plan
- Reset release, `rx`=1, `rda`=1: `rd`=0 and `da`=0 indefinitely; no pulses.
- Send 0x61 ('a'), `rda`=1: `rd`=7'h41 and `da` rises 3 cycles after the push. Drop `rda`: `da` falls 3 cycles later. Raise `rda`: FSM returns to O_IDLE.
- Send 0x0D then 0x0A with the terminal responsive: exactly one strobe, with `rd`=7'h0D. LF produces no strobe.
- Hold `rda`=0 and send 17 bytes 0x41..0x51: `overrun` pulses once on byte 17. Release the handshake: 16 strobes, 0x41..0x50 in order.
- Byte with stop bit 0: `frame_err` pulses 1 cycle, nothing is pushed, and the next valid byte is received correctly.
- Glitch `rx` low for `CLKS_PER_BIT/4` cycles: no byte is received. Assert `mr_n`=0 during O_STROBE: `da` goes to 0 asynchronously and the FIFO is empty after release.
